comp_enc_seq: RTL and testbench



---
 rtl/comp_enc_seq_if.sv | 16 +
 rtl/comp_enc_seq.sv | 102 ++++++++++
 tb/tb_comp_enc_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/comp_enc_seq_if.sv
// Operand/result bundle for comp_enc_seq: start handshake, operands, and compare flags.
interface comp_enc_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             grtr_out;
  logic             eql_out;

  modport master (output start, sgn, a, b, input busy, done, grtr_out, eql_out);
  modport slave  (input start, sgn, a, b, output busy, done, grtr_out, eql_out);
endinterface

// File: rtl/comp_enc_seq.sv
// Iterative MSB-first magnitude comparator, DIGIT bits per cycle, signed or unsigned.
// Optional COMP_ENC_EARLY_EXIT_EN: finish as soon as the first differing digit is seen.
module comp_enc_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  comp_enc_seq_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             sgn_r;
  logic [CW-1:0]    cnt;
  logic             decided, gt;
  logic             grtr_r, eql_r;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             decided_nx, gt_nx, last, accept;

  // Digit compare; the signed case flips the sign bits of the top digit so that
  // an unsigned compare of the biased values orders two's complement correctly.
  always_comb begin
    dig_a = a_sh[WIDTH-1 -: DIGIT];
    dig_b = b_sh[WIDTH-1 -: DIGIT];
    if (sgn_r && cnt == '0) begin
      dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
      dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
    end
    decided_nx = decided | (dig_a != dig_b);
    gt_nx      = decided ? gt : (dig_a > dig_b);
    last       = (cnt == CW'(N - 1));
    accept     = bus.start && (state != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_nx = DONE;
`ifdef COMP_ENC_EARLY_EXIT_EN
        else if (!decided && decided_nx) state_nx = DONE;
`endif
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = bus.start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result flags are written only on the RUN->DONE transition and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sgn_r   <= 1'b0;
      cnt     <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
      grtr_r  <= 1'b0;
      eql_r   <= 1'b0;
    end else if (accept) begin
      a_sh    <= bus.a;
      b_sh    <= bus.b;
      sgn_r   <= bus.sgn;
      cnt     <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
    end else if (state == RUN) begin
      a_sh    <= a_sh << DIGIT;
      b_sh    <= b_sh << DIGIT;
      cnt     <= cnt + CW'(1);
      decided <= decided_nx;
      gt      <= gt_nx;
      if (state_nx == DONE) begin
        grtr_r <= decided_nx & gt_nx;
        eql_r  <= ~decided_nx;
      end
    end
  end

  assign bus.grtr_out = grtr_r;
  assign bus.eql_out  = eql_r;

endmodule

// File: tb/tb_comp_enc_seq.sv
// Directed bench for comp_enc_seq: latency, flags, ignored/back-to-back starts, mid-run reset.
module tb_comp_enc_seq;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
`ifdef COMP_ENC_EARLY_EXIT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 9;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  comp_enc_seq_if #(.WIDTH(WIDTH)) bus();

  comp_enc_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the accept edge, i.e. while sampling the first RUN cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sgn   = sgn;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic measure(input int startCyc, output int lat, output int busyCnt);
    lat     = startCyc;
    busyCnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busyCnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input int expLat, input logic expG, input logic expE);
    int lat, busyCnt;
    applyStimulus(a, b, sgn);
    measure(1, lat, busyCnt);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " busy_cycles"}, busyCnt, expLat - 1);
    checkOutput({tag, " grtr"}, bus.grtr_out, expG);
    checkOutput({tag, " eql"}, bus.eql_out, expE);
    @(posedge clk);
    #1;
    checkOutput({tag, " done_pulse"}, bus.done, 0);
    checkOutput({tag, " grtr_hold"}, bus.grtr_out, expG);
  endtask

  initial begin
    int lat, busyCnt, doneSeen;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    #12;
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset grtr", bus.grtr_out, 0);
    checkOutput("reset eql", bus.eql_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("u_5_3",      32'd5,        32'd3,        1'b0, 9,         1'b1, 1'b0);
    runOp("eq_u",       32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 9,         1'b0, 1'b1);
    runOp("eq_s",       32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 9,         1'b0, 1'b1);
    runOp("ff_1_u",     32'hFFFFFFFF, 32'd1,        1'b0, EARLY_LAT, 1'b1, 1'b0);
    runOp("ff_1_s",     32'hFFFFFFFF, 32'd1,        1'b1, EARLY_LAT, 1'b0, 1'b0);
    runOp("min_max_s",  32'h80000000, 32'h7FFFFFFF, 1'b1, EARLY_LAT, 1'b0, 1'b0);
    runOp("pos_neg_s",  32'd1,        32'hFFFFFFF0, 1'b1, EARLY_LAT, 1'b1, 1'b0);
    runOp("m2_m1_s",    32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 9,         1'b0, 1'b0);
    runOp("msb_u",      32'h80000000, 32'd0,        1'b0, EARLY_LAT, 1'b1, 1'b0);

    // Start pulse during RUN must neither alter the result nor be queued.
    applyStimulus(32'd5, 32'd3, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    measure(4, lat, busyCnt);
    checkOutput("ignored latency", lat, 9);
    checkOutput("ignored grtr", bus.grtr_out, 1);
    checkOutput("ignored eql", bus.eql_out, 0);
    @(posedge clk);
    #1;
    checkOutput("ignored not_queued", bus.busy, 0);

    // Start held through DONE: second operation accepted back-to-back.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd2;
    bus.b     = 32'd7;
    bus.sgn   = 1'b0;
    @(posedge clk);
    #1;
    bus.a = 32'd7;
    bus.b = 32'd7;
    measure(1, lat, busyCnt);
    checkOutput("b2b first latency", lat, 9);
    checkOutput("b2b first grtr", bus.grtr_out, 0);
    checkOutput("b2b first eql", bus.eql_out, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("b2b restart busy", bus.busy, 1);
    measure(1, lat, busyCnt);
    checkOutput("b2b second latency", lat, 9);
    checkOutput("b2b second eql", bus.eql_out, 1);

    // Reset in the middle of RUN abandons the operation.
    applyStimulus(32'd5, 32'd3, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst busy", bus.busy, 0);
    checkOutput("midrst done", bus.done, 0);
    checkOutput("midrst grtr", bus.grtr_out, 0);
    checkOutput("midrst eql", bus.eql_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) doneSeen++;
    end
    checkOutput("midrst no_done", doneSeen, 0);
    runOp("after_rst", 32'd5, 32'd3, 1'b0, 9, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
